pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline (FETCH, DEC, EX, MEM, WB; 16-bit instructions, 32-bit data, 8 registers).
- Detects RAW dependencies at DEC and produces registered EX-stage forwarding selects.
- Stalls FETCH/DEC on load-use hazards and bubbles or flushes stage registers on taken jump/branch.
- Runs the halt-drain state machine and keeps saturating stall/flush event counters.

Parameters:
- CNT_W, 16, width of the stall/flush event counters.
- DRAIN_MAX, 3, cycles from DRAIN entry until wb_halt must be seen.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dec_rs1  in  3  DEC source register A.
- dec_rs2  in  3  DEC source register B.
- dec_rs1_used  in  1  DEC instruction reads rs1.
- dec_rs2_used  in  1  DEC instruction reads rs2.
- dec_halt  in  1  DEC instruction is halt.
- ex_write_reg  in  3  EX destination register.
- ex_write_en  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- mem_write_reg  in  3  MEM destination register.
- mem_write_en  in  1  MEM instruction writes a register.
- ex_jorb  in  1  EX resolved a taken jump/branch this cycle.
- wb_halt  in  1  halt has reached WB.
- pc_en  out  1  PC update enable.
- fd_en  out  1  FETCH/DEC register load enable.
- fd_flush  out  1  load NOP (16'h1000) into the FETCH/DEC register.
- de_bubble  out  1  clear the DEC/EX control register (write_en, MemWrite, MemRead, halt, branch, jump all 0).
- fwd_a  out  2  EX operand A select: 0 = register file, 1 = MEM ALU result, 2 = WB write data.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- halted  out  1  core halted.
- drain_err  out  1  wb_halt not seen within DRAIN_MAX cycles.
- stall_cnt  out  CNT_W  load-use stall cycle count.
- flush_cnt  out  CNT_W  flush event count.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN; fwd_a=fwd_b=0; halted=0; drain_err=0; counters=0.
  - pc_en=0, fd_en=0, de_bubble=1 while reset is held.
- Register file performs write-before-read internally, so a WB-stage write vs a DEC read needs no action here.
- hit_ex_a = dec_rs1_used & ex_write_en & (ex_write_reg==dec_rs1). hit_mem_a, hit_ex_b and hit_mem_b follow the same form. r0 is an ordinary register.
- load_use = ex_mem_read & (hit_ex_a | hit_ex_b).
- stall = load_use & !ex_jorb & state==RUN.
- Combinational outputs, by state:
  - RUN, ex_jorb=1: pc_en=1, fd_en=1, fd_flush=1, de_bubble=1. Flush has priority over stall.
  - RUN, stall: pc_en=0, fd_en=0, de_bubble=1.
  - RUN, otherwise: pc_en=1, fd_en=1, fd_flush=0, de_bubble=0.
  - DRAIN: pc_en=0, fd_en=0, de_bubble=1.
  - HALTED: pc_en=0, fd_en=0, de_bubble=1.
- Forwarding selects, registered at every edge:
  - If de_bubble=1, fwd_a=fwd_b=0.
  - Otherwise fwd_a = hit_ex_a ? 1 : (hit_mem_a ? 2 : 0). EX match wins because it is the younger producer.
  - fwd_b is computed the same way from the B hits.
  - Selects are valid in the cycle the consumer is in EX.
  - After a load-use stall, the load sits in MEM, so the retried DEC sees hit_mem and the selects become 2.
- State machine:
  - RUN -> DRAIN when dec_halt & !stall & !ex_jorb; the drain counter loads 0. dec_halt together with ex_jorb squashes the halt and the state stays RUN.
  - DRAIN: drain counter increments each cycle. DRAIN -> HALTED when wb_halt=1. If the count reaches DRAIN_MAX+1 with no wb_halt, drain_err=1 (sticky) and go to HALTED.
  - HALTED: terminal until reset; halted=1, registered, asserted the cycle after the transition edge.
  - ex_jorb in DRAIN or HALTED is ignored.
- Counters:
  - stall_cnt +1 per cycle with stall=1.
  - flush_cnt +1 per cycle with state==RUN & ex_jorb.
  - Both saturate at all-ones, never wrap, and are cleared only by reset.
- Reset mid-operation (any state): immediate return to reset values; no pending stall or drain survives.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - forwarding encodings FWD_REG=0, FWD_MEM=1, FWD_WB=2.
  - NOP_INST=16'h1000.
- One natural sub-module, fwd_sel: purely combinational hit/priority logic, instantiated once per operand.
- The FSM, counters and registered selects stay in pipe_hazard_ctrl.

Test Plan:
1. ALU op writing r1 in EX (ex_write_en=1, ex_mem_read=0); DEC reads r1 as rs1 -> no stall, pc_en=1; next cycle fwd_a=1, fwd_b=0.
2. Load to r2 in EX; DEC reads r2 as rs2 -> one cycle of pc_en=0, fd_en=0, de_bubble=1, stall_cnt 0->1. Retry cycle (mem_write_reg=2, ex_write_en=0) -> no stall; next cycle fwd_b=2.
3. Load-use condition together with ex_jorb=1 -> fd_flush=1, de_bubble=1, pc_en=1, no stall; flush_cnt 0->1, stall_cnt unchanged.
4. dec_halt=1 in RUN with no hazard -> DRAIN; pc_en=0; wb_halt=1 three cycles later -> halted=1, held for 10+ cycles, drain_err=0.
5. dec_halt=1 with ex_jorb=1 in the same cycle -> state stays RUN, pc_en=1. Separately, DRAIN entered with wb_halt never asserted -> drain_err=1 and halted=1 after 4 cycles.
6. rst driven low asynchronously mid-DRAIN with stall_cnt=5 -> state RUN, counters 0, fwd=0. After release, step 1 replays identically.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller.
//   - Controller FSM states (RUN / DRAIN / HALTED)
//   - EX-stage operand forwarding selects
//   - NOP instruction word used when flushing FETCH/DEC
package pipe_ctrl_pkg;

  localparam int REG_W = 3;  // 8 architectural registers

  // Controller states
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'd0;  // register file read data
  localparam logic [1:0] FWD_MEM = 2'd1;  // ALU result held in the MEM stage
  localparam logic [1:0] FWD_WB  = 2'd2;  // write data held in the WB stage

  localparam logic [15:0] NOP_INST = 16'h1000;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand RAW hit detection and forwarding priority, purely combinational.
// Ports:
//   rs, rs_used                  DEC source register and its read enable
//   ex_write_reg, ex_write_en    producer currently in EX
//   mem_write_reg, mem_write_en  producer currently in MEM
//   hit_ex, hit_mem              RAW match against EX / MEM producer
//   sel                          forwarding select for when this consumer reaches EX
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             rs_used,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_write_en,
  input  logic [REG_W-1:0] mem_write_reg,
  input  logic             mem_write_en,
  output logic             hit_ex,
  output logic             hit_mem,
  output logic [1:0]       sel
);

  // r0 is an ordinary register, so no zero-register exclusion here.
  assign hit_ex  = rs_used & ex_write_en  & (ex_write_reg  == rs);
  assign hit_mem = rs_used & mem_write_en & (mem_write_reg == rs);

  // One cycle later the EX producer sits in MEM and the MEM producer in WB.
  // The EX producer is younger, so its value wins.
  always_comb begin
    // NOTE: default assignment first so every path drives sel and no latch is inferred.
    sel = FWD_REG;
    if (hit_ex)       sel = FWD_MEM;
    else if (hit_mem) sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing controller for the 5-stage pipeline.
// Ports:
//   clk, rst (async, active-low)
//   dec_*          DEC-stage source registers, read enables, halt flag
//   ex_*, mem_*    destination register / write enable / load flag of EX and MEM
//   ex_jorb        taken jump/branch resolved in EX
//   wb_halt        halt instruction has reached WB
//   pc_en, fd_en   PC and FETCH/DEC register enables
//   fd_flush       load NOP into FETCH/DEC
//   de_bubble      clear DEC/EX control fields
//   fwd_a, fwd_b   registered EX operand forwarding selects
//   halted         core halted (registered)
//   drain_err      wb_halt not seen within the drain window (sticky)
//   stall_cnt, flush_cnt  saturating event counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DRAIN_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic             dec_halt,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_write_en,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_write_reg,
  input  logic             mem_write_en,
  input  logic             ex_jorb,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic             drain_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int            DW         = $clog2(DRAIN_MAX + 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX);

  logic [1:0]    state, state_next;
  logic [DW-1:0] drain_cnt, drain_next;
  logic          err_set;

  logic       hit_ex_a, hit_mem_a, hit_ex_b, hit_mem_b;
  logic [1:0] sel_a, sel_b;
  logic       load_use, stall, flush_evt;

  fwd_sel u_fwd_a (
    .rs           (dec_rs1),
    .rs_used      (dec_rs1_used),
    .ex_write_reg (ex_write_reg),
    .ex_write_en  (ex_write_en),
    .mem_write_reg(mem_write_reg),
    .mem_write_en (mem_write_en),
    .hit_ex       (hit_ex_a),
    .hit_mem      (hit_mem_a),
    .sel          (sel_a)
  );

  fwd_sel u_fwd_b (
    .rs           (dec_rs2),
    .rs_used      (dec_rs2_used),
    .ex_write_reg (ex_write_reg),
    .ex_write_en  (ex_write_en),
    .mem_write_reg(mem_write_reg),
    .mem_write_en (mem_write_en),
    .hit_ex       (hit_ex_b),
    .hit_mem      (hit_mem_b),
    .sel          (sel_b)
  );

  // A taken jump/branch squashes the dependent DEC instruction, so it must
  // not also stall.
  assign load_use  = ex_mem_read & (hit_ex_a | hit_ex_b);
  assign stall     = load_use & ~ex_jorb & (state == RUN);
  assign flush_evt = ex_jorb & (state == RUN);

  // Pipeline enables. Outside RUN, and while reset is held, the front end is
  // frozen and bubbles are injected into EX.
  always_comb begin
    pc_en     = 1'b0;
    fd_en     = 1'b0;
    fd_flush  = 1'b0;
    de_bubble = 1'b1;
    if (rst && state == RUN) begin
      if (ex_jorb) begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b1;
      end else if (!stall) begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        de_bubble = 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    err_set    = 1'b0;
    case (state)
      RUN: begin
        // A halt in the shadow of a taken branch is squashed; a stalled halt
        // is retried next cycle.
        if (dec_halt && !stall && !ex_jorb) begin
          state_next = DRAIN;
          drain_next = '0;
        end
      end
      DRAIN: begin
        if (wb_halt) begin
          state_next = HALTED;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_next = HALTED;
          err_set    = 1'b1;
        end else begin
          drain_next = drain_cnt + 1'b1;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
      drain_err <= 1'b0;
      fwd_a     <= FWD_REG;
      fwd_b     <= FWD_REG;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= state_next;
      drain_cnt <= drain_next;
      halted    <= halted | (state_next == HALTED);
      drain_err <= drain_err | err_set;
      // A bubbled EX slot carries no consumer, so its selects are parked.
      fwd_a     <= de_bubble ? FWD_REG : sel_a;
      fwd_b     <= de_bubble ? FWD_REG : sel_b;
      if (stall && stall_cnt != '1)     stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
